// File: rtl/fptd_ctrl_pkg.sv
// Shared types and constants for the Razor iteration controller:
// FSM state encoding and the error-counter width and saturation value.
package fptd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPLAY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_SAT = 8'd255;

  // Increment that sticks at the saturation value instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (cnt == ERR_CNT_SAT) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/razor_err_collector.sv
// Collapses the three per-section Razor flag vectors into one any-error bit
// and holds the captured vectors that are fed back to the sections.
module razor_err_collector #(
  parameter int K = 104
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [K-1:0] cur_alpha,
  input  logic [K-1:0] cur_beta,
  input  logic [K-1:0] cur_be1,
  input  logic         capture,
  input  logic         clear,
  output logic         any_err,
  output logic [K-1:0] prev_alpha,
  output logic [K-1:0] prev_beta,
  output logic [K-1:0] prev_be1
);

  logic [K-1:0] sec_err;
  logic [K-1:0] prev_alpha_reg;
  logic [K-1:0] prev_beta_reg;
  logic [K-1:0] prev_be1_reg;

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_sec
      assign sec_err[gi] = cur_alpha[gi] | cur_beta[gi] | cur_be1[gi];
    end
  endgenerate

  assign any_err = |sec_err;

  // Clear wins over capture so an abort can never leave stale flags behind.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      prev_alpha_reg <= '0;
      prev_beta_reg  <= '0;
      prev_be1_reg   <= '0;
    end else if (capture) begin
      prev_alpha_reg <= cur_alpha;
      prev_beta_reg  <= cur_beta;
      prev_be1_reg   <= cur_be1;
    end
  end

  assign prev_alpha = prev_alpha_reg;
  assign prev_beta  = prev_beta_reg;
  assign prev_be1   = prev_be1_reg;

endmodule

// File: rtl/razor_iter_ctrl.sv
// Razor-protected decoder iteration controller: runs IMAX clean iterations,
// replays on timing errors. Error statistics are built only with RAZOR_ERR_STATS_EN.
module razor_iter_ctrl
  import fptd_ctrl_pkg::*;
#(
  parameter int K             = 104,
  parameter int IMAX          = 8,
  parameter int REPLAY_CYCLES = 1,
  parameter int ERR_LIMIT     = 16
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Abort,
  input  logic [K-1:0]               Error_current_Alpha,
  input  logic [K-1:0]               Error_current_Beta,
  input  logic [K-1:0]               Error_current_be1,
  output logic                       Enable,
  output logic [K-1:0]               Error_previous_Alpha,
  output logic [K-1:0]               Error_previous_Beta,
  output logic [K-1:0]               Error_previous_be1,
  output logic [$clog2(IMAX+1)-1:0]  Iter,
  output logic                       Busy,
  output logic                       Done,
  output logic [ERR_CNT_W-1:0]       ErrCount,
  output logic                       Throttle
);

  localparam int IW = $clog2(IMAX + 1);
  localparam int RW = (REPLAY_CYCLES > 1) ? $clog2(REPLAY_CYCLES) : 1;
  localparam logic [IW-1:0] ITER_LAST  = IW'(IMAX - 1);
  localparam logic [RW-1:0] REPLAY_TOP = RW'(REPLAY_CYCLES - 1);

  state_t          state_reg, state_next;
  logic [IW-1:0]   iter_reg, iter_next;
  logic [RW-1:0]   replay_reg, replay_next;
  logic            enable_reg, busy_reg, done_reg;
  logic            any_err;
  logic            capture;
  logic            prev_clear;
  logic            start_acc;
  logic            err_evt;

  razor_err_collector #(
    .K(K)
  ) u_collector (
    .clk        (Clock),
    .srst       (Reset),
    .cur_alpha  (Error_current_Alpha),
    .cur_beta   (Error_current_Beta),
    .cur_be1    (Error_current_be1),
    .capture    (capture),
    .clear      (prev_clear),
    .any_err    (any_err),
    .prev_alpha (Error_previous_Alpha),
    .prev_beta  (Error_previous_Beta),
    .prev_be1   (Error_previous_be1)
  );

  always_comb begin
    state_next  = state_reg;
    iter_next   = iter_reg;
    replay_next = replay_reg;
    capture     = 1'b0;
    prev_clear  = 1'b0;
    start_acc   = 1'b0;
    err_evt     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (Start && !Abort) begin
          state_next = RUN;
          iter_next  = '0;
          start_acc  = 1'b1;
        end
      end
      RUN: begin
        if (Abort) begin
          state_next = IDLE;
          prev_clear = 1'b1;
        end else if (any_err) begin
          state_next  = REPLAY;
          replay_next = REPLAY_TOP;
          capture     = 1'b1;
          err_evt     = 1'b1;
        end else begin
          iter_next = iter_reg + 1'b1;
          if (iter_reg == ITER_LAST) begin
            state_next = DONE;
          end
        end
      end
      REPLAY: begin
        // Flags stay captured for the whole replay and drop on re-entry to RUN.
        if (Abort) begin
          state_next = IDLE;
          prev_clear = 1'b1;
        end else if (replay_reg == '0) begin
          state_next = RUN;
          prev_clear = 1'b1;
        end else begin
          replay_next = replay_reg - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        prev_clear = Abort;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg  <= IDLE;
      iter_reg   <= '0;
      replay_reg <= '0;
      enable_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      iter_reg   <= iter_next;
      replay_reg <= replay_next;
      enable_reg <= (state_next == RUN);
      busy_reg   <= (state_next == RUN) || (state_next == REPLAY);
      done_reg   <= (state_next == DONE);
    end
  end

  assign Enable = enable_reg;
  assign Busy   = busy_reg;
  assign Done   = done_reg;
  assign Iter   = iter_reg;

`ifdef RAZOR_ERR_STATS_EN
  logic [ERR_CNT_W-1:0] err_cnt_reg;
  logic [ERR_CNT_W-1:0] err_cnt_next;
  logic                 throttle_reg;

  assign err_cnt_next = err_cnt_inc(err_cnt_reg);

  // Throttle latches in the same cycle the count reaches the limit.
  always_ff @(posedge Clock) begin
    if (Reset || start_acc) begin
      err_cnt_reg  <= '0;
      throttle_reg <= 1'b0;
    end else if (err_evt) begin
      err_cnt_reg  <= err_cnt_next;
      throttle_reg <= throttle_reg || (32'(err_cnt_next) >= ERR_LIMIT);
    end
  end

  assign ErrCount = err_cnt_reg;
  assign Throttle = throttle_reg;
`else
  logic unused_stats;
  assign unused_stats = start_acc ^ err_evt;
  assign ErrCount     = '0;
  assign Throttle     = 1'b0;
`endif

endmodule

// File: tb/tb_razor_iter_ctrl.sv
// Self-checking bench for razor_iter_ctrl: cycle tables drive stimulus and queue
// the expected registered outputs, which are popped and compared after each edge.
module tb_razor_iter_ctrl;

`ifdef RAZOR_ERR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int K = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start_a, abort_a, start_b, abort_b;
  logic [K-1:0] ea_a, eb_a, ee_a, ea_b, eb_b, ee_b;
  logic         enable_a, busy_a, done_a, throttle_a;
  logic         enable_b, busy_b, done_b, throttle_b;
  logic [K-1:0] pa_a, pb_a, pe_a, pa_b, pb_b, pe_b;
  logic [1:0]   iter_a, iter_b;
  logic [7:0]   ec_a, ec_b;

  razor_iter_ctrl #(.K(K), .IMAX(3), .REPLAY_CYCLES(1), .ERR_LIMIT(2)) dut_a (
    .Clock(clk), .Reset(reset), .Start(start_a), .Abort(abort_a),
    .Error_current_Alpha(ea_a), .Error_current_Beta(eb_a), .Error_current_be1(ee_a),
    .Enable(enable_a), .Error_previous_Alpha(pa_a), .Error_previous_Beta(pb_a),
    .Error_previous_be1(pe_a), .Iter(iter_a), .Busy(busy_a), .Done(done_a),
    .ErrCount(ec_a), .Throttle(throttle_a)
  );

  razor_iter_ctrl #(.K(K), .IMAX(3), .REPLAY_CYCLES(2), .ERR_LIMIT(16)) dut_b (
    .Clock(clk), .Reset(reset), .Start(start_b), .Abort(abort_b),
    .Error_current_Alpha(ea_b), .Error_current_Beta(eb_b), .Error_current_be1(ee_b),
    .Enable(enable_b), .Error_previous_Alpha(pa_b), .Error_previous_Beta(pb_b),
    .Error_previous_be1(pe_b), .Iter(iter_b), .Busy(busy_b), .Done(done_b),
    .ErrCount(ec_b), .Throttle(throttle_b)
  );

  // Output vector: {enable, busy, done, iter[1:0], errcount[7:0], throttle, prevA, prevB, prevE}
  logic [25:0] obs_a, obs_b;
  assign obs_a = {enable_a, busy_a, done_a, iter_a, ec_a, throttle_a, pa_a, pb_a, pe_a};
  assign obs_b = {enable_b, busy_b, done_b, iter_b, ec_b, throttle_b, pa_b, pb_b, pe_b};

  typedef struct packed {
    logic        rst;
    logic        st;
    logic        ab;
    logic [3:0]  ea;
    logic [3:0]  eb;
    logic [3:0]  ee;
    logic [25:0] ex;
  } row_t;

  int          checks = 0;
  int          fails  = 0;
  logic [25:0] exp_q[$];
  logic [25:0] e;
  row_t        rows[$];

  function automatic logic [25:0] ex(bit en, bit bs, bit dn, int it, int ec, bit th,
                                     logic [3:0] pa, logic [3:0] pb, logic [3:0] pe);
    logic [7:0] ecv;
    logic       thv;
    ecv = STATS ? 8'(ec) : 8'd0;
    thv = STATS ? th : 1'b0;
    return {en, bs, dn, 2'(it), ecv, thv, pa, pb, pe};
  endfunction

  function automatic row_t mk(bit rst, bit st, bit ab, logic [3:0] ea, logic [3:0] eb,
                              logic [3:0] ee, logic [25:0] x);
    row_t r;
    r.rst = rst; r.st = st; r.ab = ab; r.ea = ea; r.eb = eb; r.ee = ee; r.ex = x;
    return r;
  endfunction

  task automatic drive_a(input row_t r);
    reset = r.rst; start_a = r.st; abort_a = r.ab; ea_a = r.ea; eb_a = r.eb; ee_a = r.ee;
    start_b = 1'b0; abort_b = 1'b0; ea_b = '0; eb_b = '0; ee_b = '0;
  endtask

  task automatic drive_b(input row_t r);
    reset = r.rst; start_b = r.st; abort_b = r.ab; ea_b = r.ea; eb_b = r.eb; ee_b = r.ee;
    start_a = 1'b0; abort_a = 1'b0; ea_a = '0; eb_a = '0; ee_a = '0;
  endtask

  task automatic test_reset();
    rows = {};
    rows.push_back(mk(1, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive_a(rows[i]); exp_q.push_back(rows[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      $display("reset row %0d obs=%h exp=%h", i, obs_a, e);
      if (obs_a !== e) begin fails++; $display("FAIL reset row %0d: got %h required %h", i, obs_a, e); end
    end
  endtask

  task automatic test_clean_frame();
    rows = {};
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(1, 1, 0, 1, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(1, 1, 0, 2, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(0, 0, 1, 3, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 3, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive_a(rows[i]); exp_q.push_back(rows[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      $display("clean row %0d obs=%h exp=%h", i, obs_a, e);
      if (obs_a !== e) begin fails++; $display("FAIL clean row %0d: got %h required %h", i, obs_a, e); end
    end
  endtask

  task automatic test_single_error();
    rows = {};
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(1, 1, 0, 1, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 4'b0010, 0, ex(0, 1, 0, 1, 1, 0, 0, 4'b0010, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(1, 1, 0, 1, 1, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(1, 1, 0, 2, 1, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(0, 0, 1, 3, 1, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 3, 1, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive_a(rows[i]); exp_q.push_back(rows[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      $display("error row %0d obs=%h exp=%h", i, obs_a, e);
      if (obs_a !== e) begin fails++; $display("FAIL error row %0d: got %h required %h", i, obs_a, e); end
    end
  endtask

  task automatic test_throttle();
    rows = {};
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 4'b0001, 0, 0, ex(0, 1, 0, 0, 1, 0, 4'b0001, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 1, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 4'b1000, ex(0, 1, 0, 0, 2, 1, 0, 0, 4'b1000)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 2, 1, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(1, 1, 0, 1, 2, 1, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(1, 1, 0, 2, 2, 1, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(0, 0, 1, 3, 2, 1, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 3, 2, 1, 0, 0, 0)));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive_a(rows[i]); exp_q.push_back(rows[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      $display("throttle row %0d obs=%h exp=%h", i, obs_a, e);
      if (obs_a !== e) begin fails++; $display("FAIL throttle row %0d: got %h required %h", i, obs_a, e); end
    end
  endtask

  task automatic test_abort();
    rows = {};
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 1, 0, 4'b0100, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 4'b0010, 0, 0, ex(0, 1, 0, 0, 1, 0, 4'b0010, 0, 0)));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive_a(rows[i]); exp_q.push_back(rows[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      $display("abort row %0d obs=%h exp=%h", i, obs_a, e);
      if (obs_a !== e) begin fails++; $display("FAIL abort row %0d: got %h required %h", i, obs_a, e); end
    end
  endtask

  task automatic test_back_to_back();
    rows = {};
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(1, 1, 0, 1, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(1, 1, 0, 2, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(0, 0, 1, 3, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(0, 0, 0, 3, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive_a(rows[i]); exp_q.push_back(rows[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      $display("b2b row %0d obs=%h exp=%h", i, obs_a, e);
      if (obs_a !== e) begin fails++; $display("FAIL b2b row %0d: got %h required %h", i, obs_a, e); end
    end
  endtask

  task automatic test_reset_mid_replay();
    rows = {};
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 4'b0011, ex(0, 1, 0, 0, 1, 0, 0, 0, 4'b0011)));
    rows.push_back(mk(1, 1, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive_a(rows[i]); exp_q.push_back(rows[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      $display("rstmid row %0d obs=%h exp=%h", i, obs_a, e);
      if (obs_a !== e) begin fails++; $display("FAIL rstmid row %0d: got %h required %h", i, obs_a, e); end
    end
  endtask

  task automatic test_replay_ignore();
    rows = {};
    rows.push_back(mk(0, 1, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 4'b0100, 0, 0, ex(0, 1, 0, 0, 1, 0, 4'b0100, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 4'b1111, 0, ex(0, 1, 0, 0, 1, 0, 4'b0100, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 4'b0001, ex(1, 1, 0, 0, 1, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 4'b0001, 0, ex(0, 1, 0, 0, 2, 0, 0, 4'b0001, 0)));
    rows.push_back(mk(0, 0, 0, 4'b0001, 0, 0, ex(0, 1, 0, 0, 2, 0, 0, 4'b0001, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 2, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(1, 1, 0, 1, 2, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(1, 1, 0, 2, 2, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(0, 0, 1, 3, 2, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 3, 2, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive_b(rows[i]); exp_q.push_back(rows[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      $display("replay2 row %0d obs=%h exp=%h", i, obs_b, e);
      if (obs_b !== e) begin fails++; $display("FAIL replay2 row %0d: got %h required %h", i, obs_b, e); end
    end
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; ea_a = '0; eb_a = '0; ee_a = '0;
    start_b = 1'b0; abort_b = 1'b0; ea_b = '0; eb_b = '0; ee_b = '0;
    test_reset();
    test_clean_frame();
    test_single_error();
    test_throttle();
    test_abort();
    test_back_to_back();
    test_reset_mid_replay();
    test_replay_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/razor_iter_ctrl.md
RAZOR_ITER_CTRL -- requirements
Module: razor_iter_ctrl

Interface
REQ-001 Parameter K, default 104: number of Razor sections controlled (frame length).
REQ-002 Parameter IMAX, default 8: clean decoding iterations per frame, at least 1.
REQ-003 Parameter REPLAY_CYCLES, default 1: Enable-low cycles per detected timing error, at least 1.
REQ-004 Parameter ERR_LIMIT, default 16: error count at which Throttle asserts.
REQ-005 Clock  input  1  the single clock; all state updates on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Start  input  1  one-cycle pulse that begins a frame decode.
REQ-008 Abort  input  1  synchronous abort of the current frame.
REQ-009 Error_current_Alpha, Error_current_Beta, Error_current_be1  input  K each  per-section Razor error flags.
REQ-010 Enable  output  1  global section enable.
REQ-011 Error_previous_Alpha, Error_previous_Beta, Error_previous_be1  output  K each  registered error flags returned to the sections.
REQ-012 Iter  output  $clog2(IMAX+1)  count of completed clean iterations.
REQ-013 Busy  output  1  high in RUN and REPLAY.
REQ-014 Done  output  1  one-cycle pulse when a frame completes.
REQ-015 ErrCount  output  8  saturating count of error events in the current frame.
REQ-016 Throttle  output  1  request to raise the supply voltage or slow the clock.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN, REPLAY and DONE.
REQ-018 IDLE: a Start pulse moves the FSM to RUN and clears Iter, ErrCount and Throttle; Enable goes to 1 in the next cycle.
REQ-019 RUN, error-free cycle (OR of all 3K flags is 0): Iter increments by 1.
REQ-020 RUN, error-free cycle with Iter == IMAX-1: Iter becomes IMAX and the FSM moves to DONE.
REQ-021 RUN, any flag set: Iter is held; the three flag vectors are captured into Error_previous_*; ErrCount increments; the FSM moves to REPLAY.
REQ-022 REPLAY: Enable = 0 for exactly REPLAY_CYCLES cycles, Error_previous_* held, Error_current_* ignored, then the FSM returns to RUN.
REQ-023 Error_previous_* SHALL clear to 0 in the first RUN cycle after REPLAY.
REQ-024 DONE: Enable = 0 and Done = 1 for one cycle, then the FSM moves to IDLE; Iter holds IMAX until the next Start.
REQ-025 Start while Busy or in DONE SHALL be ignored.
REQ-026 Abort in RUN, REPLAY or DONE SHALL move the FSM to IDLE in the next cycle with Enable = 0, Error_previous_* = 0 and no Done pulse; Abort beats a simultaneous error or completion.
REQ-027 Abort and Start in the same IDLE cycle: Abort wins and the FSM stays in IDLE.
REQ-028 ErrCount SHALL saturate at 255.
REQ-029 Throttle SHALL be registered high once ErrCount >= ERR_LIMIT and stay high until the next accepted Start or Reset.
REQ-030 Enable SHALL be 1 only in RUN; all outputs are registered.

Reset
REQ-031 On Reset the FSM goes to IDLE and all outputs are 0: Enable, Error_previous_*, Iter, Busy, Done, ErrCount, Throttle.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no Done pulse, and takes priority over Start and Abort.

Configuration
REQ-033 Macro RAZOR_ERR_STATS_EN defined: ErrCount and Throttle behave as in REQ-028 and REQ-029.
REQ-034 Macro RAZOR_ERR_STATS_EN undefined: ErrCount and Throttle are tied to 0 with no counter logic; FSM behaviour is unchanged.

Structure
REQ-035 Package fptd_ctrl_pkg SHALL hold the state enum typedef, the ErrCount width constant (8) and its saturation value (255).
REQ-036 Sub-module razor_err_collector SHALL OR-reduce the 3K flags into one any-error bit and register the capture vectors; razor_iter_ctrl instantiates it once.

Verification
REQ-037 K=4, IMAX=3, no errors, Start at cycle 0 -> Enable high for cycles 1-3, Done at cycle 4, Iter = 3.
REQ-038 Error_current_Beta = 4'b0010 in the second RUN cycle -> one Enable-low cycle, Error_previous_Beta = 4'b0010 during REPLAY then 0, Done one cycle later than in REQ-037, ErrCount = 1.
REQ-039 REPLAY_CYCLES=2, errors also driven during REPLAY -> those errors ignored, ErrCount increments once per RUN error only.
REQ-040 ERR_LIMIT=2, errors in 2 RUN cycles -> Throttle high after the second error, cleared by the next Start.
REQ-041 Abort in the same cycle as an error -> IDLE next cycle, Enable = 0, Error_previous_* = 0, no Done; Reset mid-REPLAY -> all outputs 0.
REQ-042 Build without RAZOR_ERR_STATS_EN -> ErrCount and Throttle stay 0 under REQ-038 stimulus, all other outputs identical to the build with it.
